// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 codes, write-back
// select encodings, the canonical NOP, FSM states and the MEM/WB slot layout.
package mem_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {
        WB_SEL_MEM = 2'd0,
        WB_SEL_ALU = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef struct packed {
        logic        valid;
        logic        regwen;
        logic [1:0]  wbsel;
        logic [31:0] alu;
        logic [31:0] pc_four;
        logic [31:0] mem;
        logic [31:0] inst;
    } wb_slot_t;

    localparam wb_slot_t BUBBLE = '{
        valid:   1'b0,
        regwen:  1'b0,
        wbsel:   2'b00,
        alu:     32'h0,
        pc_four: 32'h0,
        mem:     32'h0,
        inst:    NOP_INST
    };

    // Unlisted funct3 codes fall through to word access.
    function automatic size_e access_size(input logic [2:0] funct3, input logic is_load);
        size_e sz;
        sz = SZ_WORD;
        if (funct3 == F3_SB)
            sz = SZ_BYTE;
        else if (funct3 == F3_SH)
            sz = SZ_HALF;
        else if (is_load && funct3 == F3_LBU)
            sz = SZ_BYTE;
        else if (is_load && funct3 == F3_LHU)
            sz = SZ_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables / replicated write data, and
// load lane selection with sign or zero extension.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        ld_signed;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (access_size(st_funct3, 1'b0))
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        lane_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_signed = (ld_funct3 == F3_LB) || (ld_funct3 == F3_LH);
        ld_data   = ld_rdata;
        case (access_size(ld_funct3, 1'b1))
            SZ_BYTE: ld_data = {{24{ld_signed & lane_byte[7]}}, lane_byte};
            SZ_HALF: ld_data = {{16{ld_signed & lane_half[15]}}, lane_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory transaction per load/store and
// loads the MEM/WB register. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_stage
    import mem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ALU,
    input  logic [31:0] rs2_data,
    input  logic [31:0] PC_four,
    input  logic [31:0] instMEM,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  WBSel,
    input  logic        RegWEn,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        misalign,
    output logic        wb_valid,
    output logic [31:0] wb_ALU,
    output logic [31:0] wb_PC_four,
    output logic [31:0] wb_Mem,
    output logic [31:0] wb_inst,
    output logic [1:0]  wb_WBSel,
    output logic        wb_RegWEn
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    wb_slot_t    wb_q, wb_d;
    wb_slot_t    cap_q, cap_d;
    logic [2:0]  cap_f3_q, cap_f3_d;
    logic [1:0]  cap_lo_q, cap_lo_d;
    logic        cap_load_q, cap_load_d;

    logic [2:0]  funct3;
    logic        mem_op;
    logic        trap;
    logic        stall_c;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    wb_slot_t    slot;

    assign funct3 = instMEM[14:12];
    assign mem_op = mem_rd | mem_wr;

    lsu_align u_lsu_align (
        .st_funct3  (funct3),
        .st_addr_lo (ALU[1:0]),
        .st_data    (rs2_data),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_funct3  (cap_f3_q),
        .ld_addr_lo (cap_lo_q),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    size_e trap_sz;
    logic  misalign_q, misalign_d;

    assign trap_sz = access_size(funct3, ~mem_wr);
    assign trap    = ex_valid & mem_op & ~flush &
                     (((trap_sz == SZ_HALF) & ALU[0]) | ((trap_sz == SZ_WORD) & (|ALU[1:0])));
    assign misalign_d = (state_q == IDLE) & trap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        slot         = BUBBLE;
        slot.valid   = 1'b1;
        slot.regwen  = RegWEn;
        slot.wbsel   = WBSel;
        slot.alu     = ALU;
        slot.pc_four = PC_four;
        slot.inst    = instMEM;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_d      = cap_q;
        cap_f3_d   = cap_f3_q;
        cap_lo_d   = cap_lo_q;
        cap_load_d = cap_load_q;
        wb_d       = BUBBLE;
        stall_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && !flush && !trap) begin
                    if (mem_op) begin
                        state_d    = REQ;
                        req_d      = 1'b1;
                        we_d       = mem_wr;
                        be_d       = mem_wr ? st_be : 4'b1111;
                        addr_d     = {ALU[31:2], 2'b00};
                        wdata_d    = mem_wr ? st_wdata : 32'h0;
                        cap_d      = slot;
                        cap_f3_d   = funct3;
                        cap_lo_d   = ALU[1:0];
                        cap_load_d = ~mem_wr;
                        stall_c    = 1'b1;
                    end else begin
                        wb_d = slot;
                    end
                end
            end
            REQ: begin
                // A flush here only kills the slot; the bus cycle must still finish.
                if (flush)
                    cap_d.valid = 1'b0;
                if (dmem_ack) begin
                    wb_d       = cap_q;
                    wb_d.valid = cap_q.valid & ~flush;
                    wb_d.mem   = cap_load_q ? ld_data : 32'h0;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
        endcase

        if (!wb_d.valid)
            wb_d = BUBBLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wb_q       <= BUBBLE;
            cap_q      <= BUBBLE;
            cap_f3_q   <= 3'b000;
            cap_lo_q   <= 2'b00;
            cap_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_q       <= wb_d;
            cap_q      <= cap_d;
            cap_f3_q   <= cap_f3_d;
            cap_lo_q   <= cap_lo_d;
            cap_load_q <= cap_load_d;
        end
    end

    assign mem_stall  = stall_c & i_rst_n;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_q.valid;
    assign wb_RegWEn  = wb_q.regwen & wb_q.valid;
    assign wb_WBSel   = wb_q.wbsel;
    assign wb_ALU     = wb_q.alu;
    assign wb_PC_four = wb_q.pc_four;
    assign wb_Mem     = wb_q.mem;
    assign wb_inst    = wb_q.inst;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed slots push expected MEM/WB contents,
// a monitor pops and compares on every cycle that presents wb_valid.
module tb_mem_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        ex_valid;
    logic [31:0] ALU, rs2_data, PC_four, instMEM;
    logic        mem_rd, mem_wr;
    logic [1:0]  WBSel;
    logic        RegWEn, flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall, misalign;
    logic        wb_valid;
    logic [31:0] wb_ALU, wb_PC_four, wb_Mem, wb_inst;
    logic [1:0]  wb_WBSel;
    logic        wb_RegWEn;

    mem_stage dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .ex_valid   (ex_valid),
        .ALU        (ALU),
        .rs2_data   (rs2_data),
        .PC_four    (PC_four),
        .instMEM    (instMEM),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .WBSel      (WBSel),
        .RegWEn     (RegWEn),
        .flush      (flush),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_stall  (mem_stall),
        .misalign   (misalign),
        .wb_valid   (wb_valid),
        .wb_ALU     (wb_ALU),
        .wb_PC_four (wb_PC_four),
        .wb_Mem     (wb_Mem),
        .wb_inst    (wb_inst),
        .wb_WBSel   (wb_WBSel),
        .wb_RegWEn  (wb_RegWEn)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] mem;
        logic [31:0] inst;
        logic [1:0]  wbsel;
        logic        regwen;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
        return {17'h0, f3, 5'd1, opc};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] alu, pc4, mem, inst,
                                     input logic [1:0] wbsel, input logic regwen);
        exp_t e;
        e.alu = alu; e.pc4 = pc4; e.mem = mem; e.inst = inst;
        e.wbsel = wbsel; e.regwen = regwen;
        return e;
    endfunction

    // Monitor: compares every presented MEM/WB slot against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n === 1'b1) begin
                if (wb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("wb_valid without expected slot", {31'b0, wb_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_ALU", wb_ALU, e.alu);
                        check("wb_PC_four", wb_PC_four, e.pc4);
                        check("wb_Mem", wb_Mem, e.mem);
                        check("wb_inst", wb_inst, e.inst);
                        check("wb_WBSel", {30'b0, wb_WBSel}, {30'b0, e.wbsel});
                        check("wb_RegWEn", {31'b0, wb_RegWEn}, {31'b0, e.regwen});
                    end
                end else begin
                    check("wb_RegWEn masked by wb_valid", {31'b0, wb_RegWEn}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; RegWEn = 1'b0; flush = 1'b0;
        ALU = 32'h0; rs2_data = 32'h0; PC_four = 32'h0; instMEM = 32'h13; WBSel = 2'd0;
    endtask

    task automatic drive(input logic [31:0] alu, rs2, pc4, inst,
                         input logic rd, wr, input logic [1:0] wbsel, input logic regwen);
        ex_valid = 1'b1; ALU = alu; rs2_data = rs2; PC_four = pc4; instMEM = inst;
        mem_rd = rd; mem_wr = wr; WBSel = wbsel; RegWEn = regwen; flush = 1'b0;
    endtask

    // Called in the IDLE cycle in which a load/store has just been driven.
    task automatic bus_txn(input string tag, input int waits, input logic [31:0] rdata,
                           input logic flush_req, input logic [31:0] e_addr,
                           input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wdata);
        @(negedge i_clk);
        check({tag, " issue stall"}, {31'b0, mem_stall}, 32'd1);
        for (int w = 0; w < waits; w++) begin
            step();
            flush = (flush_req && w == 0);
            @(negedge i_clk);
            check({tag, " wait stall"}, {31'b0, mem_stall}, 32'd1);
            check({tag, " wait dmem_req"}, {31'b0, dmem_req}, 32'd1);
        end
        step();
        flush = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        @(negedge i_clk);
        check({tag, " ack stall"}, {31'b0, mem_stall}, 32'd0);
        check({tag, " dmem_req"}, {31'b0, dmem_req}, 32'd1);
        check({tag, " dmem_addr"}, dmem_addr, e_addr);
        check({tag, " dmem_we"}, {31'b0, dmem_we}, {31'b0, e_we});
        check({tag, " dmem_be"}, {28'b0, dmem_be}, {28'b0, e_be});
        check({tag, " dmem_wdata"}, dmem_wdata, e_wdata);
        step();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
    endtask

    logic [31:0] inst;

    initial begin
        i_rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();

        repeat (2) step();
        @(negedge i_clk);
        check("reset dmem_req", {31'b0, dmem_req}, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'h0);
        check("reset dmem_be", {28'b0, dmem_be}, 32'h0);
        check("reset wb_valid", {31'b0, wb_valid}, 32'd0);
        check("reset wb_inst", wb_inst, 32'h0000_0013);
        check("reset misalign", {31'b0, misalign}, 32'd0);
        check("reset mem_stall", {31'b0, mem_stall}, 32'd0);
        step();
        i_rst_n = 1'b1;

        // ALU op: one-cycle pass-through, never stalls.
        step();
        inst = mk_inst(3'b000, 7'b0110011);
        drive(32'h40, 32'h0, 32'h104, inst, 1'b0, 1'b0, 2'd1, 1'b1);
        exp_q.push_back(mk_exp(32'h40, 32'h104, 32'h0, inst, 2'd1, 1'b1));
        @(negedge i_clk);
        check("add stall", {31'b0, mem_stall}, 32'd0);
        step();
        idle_inputs();
        @(negedge i_clk);
        check("add stall after", {31'b0, mem_stall}, 32'd0);

        // Flush in IDLE turns the slot into a bubble.
        step();
        drive(32'h55, 32'h0, 32'h108, inst, 1'b0, 1'b0, 2'd1, 1'b1);
        flush = 1'b1;
        step();
        idle_inputs();
        @(negedge i_clk);
        check("idle flush wb_valid", {31'b0, wb_valid}, 32'd0);
        check("idle flush wb_inst", wb_inst, 32'h0000_0013);
        check("idle flush wb_ALU", wb_ALU, 32'h0);

        // LB, byte lane 3, three wait cycles -> four stall cycles.
        step();
        inst = mk_inst(3'b000, 7'b0000011);
        drive(32'h103, 32'h0, 32'h208, inst, 1'b1, 1'b0, 2'd0, 1'b1);
        exp_q.push_back(mk_exp(32'h103, 32'h208, 32'hFFFF_FF80, inst, 2'd0, 1'b1));
        bus_txn("lb", 3, 32'h80FF_1234, 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0);

        // SH upper half.
        step();
        inst = mk_inst(3'b001, 7'b0100011);
        drive(32'h202, 32'h0000_ABCD, 32'h30C, inst, 1'b0, 1'b1, 2'd0, 1'b0);
        exp_q.push_back(mk_exp(32'h202, 32'h30C, 32'h0, inst, 2'd0, 1'b0));
        bus_txn("sh", 1, 32'hDEAD_BEEF, 1'b0, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD);

        // SB lane 1, minimum latency.
        step();
        inst = mk_inst(3'b000, 7'b0100011);
        drive(32'h301, 32'h1234_56A5, 32'h310, inst, 1'b0, 1'b1, 2'd0, 1'b0);
        exp_q.push_back(mk_exp(32'h301, 32'h310, 32'h0, inst, 2'd0, 1'b0));
        bus_txn("sb", 0, 32'h0, 1'b0, 32'h300, 1'b1, 4'b0010, 32'hA5A5_A5A5);

        // LH upper half, sign-extended.
        step();
        inst = mk_inst(3'b001, 7'b0000011);
        drive(32'h106, 32'h0, 32'h314, inst, 1'b1, 1'b0, 2'd0, 1'b1);
        exp_q.push_back(mk_exp(32'h106, 32'h314, 32'hFFFF_8001, inst, 2'd0, 1'b1));
        bus_txn("lh", 0, 32'h8001_7FFF, 1'b0, 32'h104, 1'b0, 4'b1111, 32'h0);

        // LBU lane 2, zero-extended.
        step();
        inst = mk_inst(3'b100, 7'b0000011);
        drive(32'h2, 32'h0, 32'h318, inst, 1'b1, 1'b0, 2'd0, 1'b1);
        exp_q.push_back(mk_exp(32'h2, 32'h318, 32'h0000_00F0, inst, 2'd0, 1'b1));
        bus_txn("lbu", 1, 32'h00F0_0000, 1'b0, 32'h0, 1'b0, 4'b1111, 32'h0);

        // LHU flushed while in REQ: bus completes, slot becomes a bubble.
        step();
        inst = mk_inst(3'b101, 7'b0000011);
        drive(32'h12, 32'h0, 32'h31C, inst, 1'b1, 1'b0, 2'd0, 1'b1);
        bus_txn("lhu flush", 2, 32'hBEEF_0000, 1'b1, 32'h10, 1'b0, 4'b1111, 32'h0);
        @(negedge i_clk);
        check("lhu flush wb_valid", {31'b0, wb_valid}, 32'd0);
        check("lhu flush wb_RegWEn", {31'b0, wb_RegWEn}, 32'd0);
        check("lhu flush wb_inst", wb_inst, 32'h0000_0013);
        check("lhu flush wb_Mem", wb_Mem, 32'h0);
        check("lhu flush dmem_req", {31'b0, dmem_req}, 32'd0);

        // Misaligned LW.
        step();
        inst = mk_inst(3'b010, 7'b0000011);
        drive(32'h101, 32'h0, 32'h320, inst, 1'b1, 1'b0, 2'd0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge i_clk);
        check("lw trap stall", {31'b0, mem_stall}, 32'd0);
        step();
        idle_inputs();
        @(negedge i_clk);
        check("lw trap misalign", {31'b0, misalign}, 32'd1);
        check("lw trap dmem_req", {31'b0, dmem_req}, 32'd0);
        check("lw trap wb_valid", {31'b0, wb_valid}, 32'd0);
        check("lw trap wb_inst", wb_inst, 32'h0000_0013);
        step();
        @(negedge i_clk);
        check("lw trap misalign pulse end", {31'b0, misalign}, 32'd0);
        check("lw trap dmem_req after", {31'b0, dmem_req}, 32'd0);
`else
        exp_q.push_back(mk_exp(32'h101, 32'h320, 32'h1122_3344, inst, 2'd0, 1'b1));
        bus_txn("lw unaligned", 1, 32'h1122_3344, 1'b0, 32'h100, 1'b0, 4'b1111, 32'h0);
        @(negedge i_clk);
        check("lw misalign tied", {31'b0, misalign}, 32'd0);
`endif

        // Reset while in REQ abandons the transaction; a late ack is ignored.
        step();
        inst = mk_inst(3'b010, 7'b0000011);
        drive(32'h400, 32'h0, 32'h324, inst, 1'b1, 1'b0, 2'd0, 1'b1);
        @(negedge i_clk);
        check("rst-req issue stall", {31'b0, mem_stall}, 32'd1);
        step();
        idle_inputs();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("rst-req dmem_req before reset", {31'b0, dmem_req}, 32'd1);
        step();
        i_rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        check("rst-req dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst-req mem_stall", {31'b0, mem_stall}, 32'd0);
        check("rst-req dmem_addr", dmem_addr, 32'h0);
        check("rst-req dmem_we", {31'b0, dmem_we}, 32'd0);
        check("rst-req dmem_be", {28'b0, dmem_be}, 32'h0);
        check("rst-req dmem_wdata", dmem_wdata, 32'h0);
        check("rst-req wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst-req wb_inst", wb_inst, 32'h0000_0013);
        check("rst-req misalign", {31'b0, misalign}, 32'd0);
        step();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        @(negedge i_clk);
        check("rst-req ack ignored dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst-req ack ignored wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst-req ack ignored wb_Mem", wb_Mem, 32'h0);

        repeat (2) step();
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: ex_valid in 1 EX/MEM slot valid; ALU in 32 ALU result/effective address; rs2_data in 32 store data; PC_four in 32; instMEM in 32 instruction.
REQ-004 SHALL have ports: mem_rd in 1 load; mem_wr in 1 store; WBSel in 2; RegWEn in 1; flush in 1 kill current slot.
REQ-005 SHALL have ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 word-aligned; dmem_wdata out 32; dmem_be out 4; dmem_rdata in 32; dmem_ack in 1 one-cycle response strobe.
REQ-006 SHALL have ports: mem_stall out 1 to hazard unit; misalign out 1 exception pulse.
REQ-007 SHALL have ports: wb_valid out 1; wb_ALU, wb_PC_four, wb_Mem, wb_inst out 32 each; wb_WBSel out 2; wb_RegWEn out 1 (MEM/WB register feeding WB).

Function
REQ-008 SHALL use FSM states IDLE, REQ; reset state IDLE.
REQ-009 SHALL, in IDLE with ex_valid=0 or no memory op, load MEM/WB register on next edge (1-cycle latency), mem_stall=0.
REQ-010 SHALL, in IDLE with ex_valid and (mem_rd or mem_wr), register dmem_addr={ALU[31:2],2'b00}, dmem_we, dmem_be, dmem_wdata, enter REQ; mem_stall=1 combinationally that cycle.
REQ-011 SHALL hold dmem_req=1 and all dmem_* stable in REQ until dmem_ack=1; mem_stall=1 in REQ while dmem_ack=0.
REQ-012 SHALL, on dmem_ack in REQ: mem_stall=0 that cycle, load MEM/WB with aligned load data (store: wb_Mem=0), drop dmem_req, return to IDLE; minimum load/store latency 2 cycles.
REQ-013 SHALL decode funct3=instMEM[14:12]: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; other codes treated as LW/SW.
REQ-014 SHALL select byte lane by ALU[1:0], halfword by ALU[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-015 SHALL generate dmem_be: SB 4'b0001<<ALU[1:0], SH 4'b0011<<{ALU[1],1'b0}, SW 4'b1111; dmem_wdata replicates byte/halfword across lanes.
REQ-016 SHALL ignore dmem_ack in IDLE.
REQ-017 SHALL, on flush in IDLE, load MEM/WB with bubble: wb_valid=0, wb_RegWEn=0, wb_inst=32'h0000_0013, other data 0.
REQ-018 SHALL, on flush in REQ, not abort the bus transaction; transaction completes, completion slot written as bubble.
REQ-019 SHALL mask wb_RegWEn with wb_valid (wb_RegWEn=0 whenever wb_valid=0).

Reset
REQ-020 SHALL, on i_rst_n=0 at edge, enter IDLE and clear dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_stall drive, misalign, wb_valid, wb_ALU, wb_PC_four, wb_Mem, wb_WBSel, wb_RegWEn to 0 and set wb_inst=32'h0000_0013.
REQ-021 SHALL, on reset during REQ, abandon the transaction immediately; a later dmem_ack is ignored.

Configuration
REQ-022 SHALL, with MEM_MISALIGN_TRAP_EN defined, detect LH/LHU/SH with ALU[0]=1 and LW/SW with ALU[1:0]!=0: no bus transaction, misalign=1 for one cycle, slot written as bubble, stays IDLE.
REQ-023 SHALL, without MEM_MISALIGN_TRAP_EN, tie misalign=0 and force natural alignment by dropping offending low address bits.

Structure
REQ-024 SHALL place funct3 load/store codes, WBSel encodings, NOP constant and FSM state enum in shared package mem_pkg.
REQ-025 SHALL implement lane selection/extension and byte-enable/wdata generation in combinational sub-module lsu_align.

Verification
REQ-026 SHALL cover: ADD, ex_valid=1, ALU=32'h0000_0040 -> next edge wb_ALU=32'h40, wb_valid=1, mem_stall never 1.
REQ-027 SHALL cover: LB, ALU=32'h103, dmem_rdata=32'h80FF_1234, ack after 3 REQ cycles -> dmem_addr=32'h100, stall 4 cycles, wb_Mem=32'hFFFF_FF80.
REQ-028 SHALL cover: SH, ALU=32'h202, rs2_data=32'h0000_ABCD -> dmem_be=4'b1100, dmem_wdata=32'hABCD_ABCD, dmem_we=1.
REQ-029 SHALL cover: LHU ALU=32'h12 rdata=32'hBEEF_0000 with flush asserted in REQ -> bus completes, wb_valid=0, wb_RegWEn=0, wb_inst=32'h13.
REQ-030 SHALL cover: LW ALU=32'h101 -> with MEM_MISALIGN_TRAP_EN misalign pulses 1 cycle, dmem_req stays 0; without it dmem_addr=32'h100, misalign=0.
REQ-031 SHALL cover: i_rst_n=0 while in REQ, then dmem_ack=1 -> state IDLE, all outputs at reset values, ack ignored.
